counter_updown_mod: RTL

//  Synchronous up/down counter: parametrised width and modulus, load, enable,

---
 rtl/cnt_pkg.sv | 20 ++
 rtl/dff_sync_r.sv | 27 ++
 rtl/counter_updown_mod.sv | 110 +++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// Shared definitions for the up/down counter family.
//   CNT_UP / CNT_DN    : encodings of the direction input
//   CNT_WRAP / CNT_SAT : end-of-range behaviour selectors for SATURATE
//   clamp_mod()        : limits a loaded value to the last legal count
package cnt_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DN   = 1'b0;
  localparam int   CNT_WRAP = 0;
  localparam int   CNT_SAT  = 1;

  // Values at or above the modulus collapse onto modulus-1. The arguments
  // are 33 bits wide so a 32-bit counter with modulus 2**32 still compares
  // correctly.
  function automatic logic [32:0] clamp_mod(input logic [32:0] val,
                                            input logic [32:0] mod);
    return (val >= mod) ? (mod - 33'd1) : val;
  endfunction

endpackage

// File: rtl/dff_sync_r.sv
// Single-bit D flip-flop with synchronous active-high reset.
//   clk       : rising-edge clock
//   reset     : synchronous reset, loads rst_val_i on the next edge
//   rst_val_i : value taken on reset
//   d_i       : next-state input
//   q_o       : registered output
module dff_sync_r (
  input  logic clk,
  input  logic reset,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= rst_val_i;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/counter_updown_mod.sv
// Synchronous up/down modulo counter with load, enable, wrap/saturate and a
// terminal-count carry for cascading. All bits update on the same edge.
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, q <= RESET_VAL
//   en       : count enable
//   up       : 1 counts up, 0 counts down
//   load     : synchronous parallel load (clamped to MODULUS-1)
//   load_val : value to load
//   q        : registered count
//   tc       : q sits at the end value for the current direction
//   carry    : tc & en & ~reset & ~load, drives the next stage's en
module counter_updown_mod
  import cnt_pkg::*;
#(
  parameter int     WIDTH     = 4,
  parameter longint MODULUS   = 16,
  parameter int     SATURATE  = CNT_WRAP,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             carry
);

  // Reject illegal configurations at elaboration time.
  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("counter_updown_mod: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_mod
      $error("counter_updown_mod: MODULUS must be 2..2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
      $error("counter_updown_mod: RESET_VAL must be below MODULUS");
    end
    if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_sat
      $error("counter_updown_mod: SATURATE must be 0 or 1");
    end
  endgenerate

  // Compares run one bit wider than the counter so MODULUS = 2**WIDTH gives
  // a representable last value without overflowing.
  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [32:0]      load_clamped;
  logic [WIDTH-1:0] count_d;
  logic             unused_bits;

  assign q_ext        = {1'b0, q};
  assign inc_ext      = q_ext + (WIDTH+1)'(1);
  assign dec_ext      = q_ext - (WIDTH+1)'(1);
  assign load_clamped = clamp_mod(33'(load_val), 33'(MODULUS));

  // The extension bits never reach q: the end-of-range cases are handled
  // before inc/dec results are used, and clamping keeps loads below 2**WIDTH.
  assign unused_bits = &{1'b0, inc_ext[WIDTH], dec_ext[WIDTH],
                         load_clamped[32:WIDTH]};

  // Next state. Reset is applied inside the flip-flops, so it already
  // overrides everything computed here.
  always_comb begin
    count_d = q;
    if (load) begin
      count_d = load_clamped[WIDTH-1:0];
    end else if (en) begin
      if (up == CNT_UP) begin
        if (q_ext == MAX_W) begin
          count_d = (SATURATE == CNT_SAT) ? q : '0;
        end else begin
          count_d = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (q_ext == '0) begin
          count_d = (SATURATE == CNT_SAT) ? q : MAX_W[WIDTH-1:0];
        end else begin
          count_d = dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  // One flip-flop per bit forms the count register.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      dff_sync_r u_bit (
        .clk       (clk),
        .reset     (reset),
        .rst_val_i (RST_W[gi]),
        .d_i       (count_d[gi]),
        .q_o       (q[gi])
      );
    end
  endgenerate

  // tc follows the live direction input, so a direction change is visible
  // in the same cycle.
  assign tc    = (up == CNT_UP) ? (q_ext == MAX_W) : (q_ext == '0);
  assign carry = tc & en & ~reset & ~load;

endmodule
